// File: rtl/button_bank.sv
// rtl/button_bank.sv - multi-channel button debouncer with press/release, long-press and auto-repeat
module button_bank #(
  parameter int N_BTN         = 5,
  parameter int NDELAY        = 650000,
  parameter int CNT_W         = 20,
  parameter int LONG_DELAY    = 100000000,
  parameter int REPEAT_PERIOD = 25000000,
  parameter int HOLD_W        = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} hold_state_t;

  localparam logic [CNT_W-1:0]  NDELAY_C = CNT_W'(NDELAY);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] LONG_C   = HOLD_W'(LONG_DELAY);
  localparam logic [HOLD_W-1:0] PERIOD_C = HOLD_W'(REPEAT_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [N_BTN-1:0]  sync_meta;
  logic [N_BTN-1:0]  sync_q;
  logic [N_BTN-1:0]  cand;
  logic [N_BTN-1:0]  prev;
  logic [N_BTN-1:0]  rpt_en_q;
  logic [CNT_W-1:0]  cnt          [N_BTN];
  hold_state_t       state        [N_BTN];
  hold_state_t       state_nxt    [N_BTN];
  logic [HOLD_W-1:0] hold_cnt     [N_BTN];
  logic [HOLD_W-1:0] hold_cnt_nxt [N_BTN];

  // Two-flop synchroniser followed by the stable-time filter; a change of the
  // synchronised level restarts the count, a saturated count commits the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
      cand      <= '0;
      level     <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      sync_meta <= btn_in;
      sync_q    <= sync_meta;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_q[i] != cand[i]) begin
          cand[i] <= sync_q[i];
          cnt[i]  <= '0;
        end else if (cnt[i] == NDELAY_C) begin
          level[i] <= cand[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Registered edge detection on the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev          <= '0;
      press         <= '0;
      release_pulse <= '0;
    end else begin
      prev          <= level;
      press         <= level & ~prev;
      release_pulse <= ~level & prev;
    end
  end

  // Hold FSM state and counter; repeat_en is registered so a re-enabled
  // repeat always waits one full period from the cycle it was applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_en_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state[i]    <= S_IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      rpt_en_q <= repeat_en;
      for (int i = 0; i < N_BTN; i++) begin
        state[i]    <= state_nxt[i];
        hold_cnt[i] <= hold_cnt_nxt[i];
      end
    end
  end

  // Next-state and pulse decode; a release pulse always takes priority over
  // a long_press or repeat that would fire in the same cycle.
  always_comb begin
    long_press   = '0;
    repeat_pulse = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_nxt[i]    = state[i];
      hold_cnt_nxt[i] = hold_cnt[i];
      case (state[i])
        S_IDLE: begin
          if (press[i]) begin
            state_nxt[i]    = S_HELD;
            hold_cnt_nxt[i] = HOLD_ONE;
          end
        end
        S_HELD: begin
          if (release_pulse[i]) begin
            state_nxt[i] = S_IDLE;
          end else if (hold_cnt[i] == LONG_C) begin
            long_press[i]   = 1'b1;
            state_nxt[i]    = S_REPEAT;
            hold_cnt_nxt[i] = HOLD_ONE;
          end else begin
            hold_cnt_nxt[i] = hold_cnt[i] + HOLD_ONE;
          end
        end
        S_REPEAT: begin
          if (release_pulse[i]) begin
            state_nxt[i] = S_IDLE;
          end else if (!rpt_en_q[i]) begin
            hold_cnt_nxt[i] = HOLD_ONE;
          end else if (hold_cnt[i] == PERIOD_C) begin
            repeat_pulse[i] = 1'b1;
            hold_cnt_nxt[i] = HOLD_ONE;
          end else begin
            hold_cnt_nxt[i] = hold_cnt[i] + HOLD_ONE;
          end
        end
        default: begin
          state_nxt[i] = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
- Multi-channel successor to the single-button debouncer.
- N_BTN asynchronous push-button inputs, each with:
  - a two-flop synchroniser,
  - a stable-time debounce filter,
  - registered press and release pulses,
  - long-press detection,
  - optional auto-repeat.
- Sits between the board buttons and the user-interface FSMs: menu navigation, value increment and hold-to-scroll.

Parameters:
- N_BTN, 5: number of independent button channels.
- NDELAY, 650000: number of consecutive cycles the synchronised input must be stable before the debounced level updates. Must be ≥ 1 and < 2^CNT_W.
- CNT_W, 20: width of the debounce counter.
- LONG_DELAY, 100000000: cycles between press and long_press. Must be ≥ 2 and < 2^HOLD_W.
- REPEAT_PERIOD, 25000000: cycles between successive repeat pulses. Must be ≥ 2 and < 2^HOLD_W.
- HOLD_W, 27: width of the hold and repeat counter.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- btn_in, input, N_BTN: raw button levels, asynchronous, 1 = pressed.
- repeat_en, input, N_BTN: per-channel auto-repeat enable, synchronous to clk.
- level, output, N_BTN: debounced level (registered).
- press, output, N_BTN: one-cycle pulse on a debounced 0→1 transition.
- release, output, N_BTN: one-cycle pulse on a debounced 1→0 transition.
- long_press, output, N_BTN: one-cycle pulse once per hold.
- repeat, output, N_BTN: one-cycle pulses during a long hold.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all outputs 0;
  - synchronisers, candidate registers, counters and previous-level registers cleared to 0;
  - every channel FSM in IDLE.
- Channels are fully independent. Simultaneous events on different channels are each handled on their own channel.
- Synchroniser: btn_in[i] passes through two flops to give sync[i].
- Debounce, per channel, evaluated each cycle in this order:
  - if sync differs from cand: cand <= sync, cnt <= 0;
  - else if cnt == NDELAY: level <= cand, and cnt holds at NDELAY (no wrap);
  - else cnt <= cnt + 1.
- Debounce latency: take the first edge that samples a new stable btn_in value as edge 1. level changes on edge NDELAY+4.
- Glitch rejection: any glitch shorter than NDELAY+1 synchronised cycles restarts the count and never reaches level.
- Edge detect: prev <= level every cycle.
  - press = level & ~prev;
  - release = ~level & prev.
  - Both are registered, so each asserts one cycle after level changes and lasts exactly 1 cycle.
- Hold FSM, per channel, driven by the press and release pulses:
  - IDLE:
    - on press go to HELD, hold_cnt <= 1.
  - HELD:
    - on release go to IDLE (no long_press);
    - else if hold_cnt == LONG_DELAY: long_press = 1 for this cycle, go to REPEAT, hold_cnt <= 1;
    - else hold_cnt increments.
    - Net effect: long_press asserts exactly LONG_DELAY cycles after press.
  - REPEAT:
    - on release go to IDLE;
    - else if repeat_en = 0: hold_cnt <= 1 and no pulse;
    - else if hold_cnt == REPEAT_PERIOD: repeat = 1 for this cycle, hold_cnt <= 1;
    - else hold_cnt increments.
    - Net effect: the first repeat comes REPEAT_PERIOD cycles after long_press; repeats continue indefinitely while held and enabled.
    - Deasserting repeat_en pauses repeating. Reasserting it restarts a full period.
- Release in the same cycle a long_press or repeat would fire: release wins. No long_press or repeat pulse is emitted and the FSM goes to IDLE.
- long_press, repeat and press are never asserted together on the same channel in the same cycle.
- Reset mid-hold: outputs drop immediately. If the button is still held after reset, it is treated as a new press after the full debounce latency.

Test Plan:
Bench parameters: N_BTN=2, NDELAY=4, LONG_DELAY=20, REPEAT_PERIOD=8.
1. Clean press of btn_in[0] held 40 cycles, then released -> level[0] rises on edge 8; press[0] high only on edge 9; release[0] one cycle at 9 edges after release sampled; channel 1 outputs stay 0.
2. btn_in[0] toggling with 3-cycle highs and 3-cycle lows for 60 cycles -> level[0], press[0] and release[0] remain 0 throughout.
3. Hold btn_in[1] with repeat_en[1]=1 for 80 cycles after press -> long_press[1] exactly 20 cycles after press[1]; repeat[1] at +8, +16, +24 … after it; none after release.
4. Hold with repeat_en=0 -> single long_press and no repeat. Assert repeat_en mid-hold -> first repeat 8 cycles after assertion.
5. Release at 19 cycles after press -> no long_press. Release timed to coincide with the long_press cycle -> release only.
6. Assert rst mid-REPEAT with the button still held -> all outputs 0 immediately; after rst drops, press reappears 9 edges later.
